// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB3 initiator turning single commands into SETUP/ACCESS transfers,
// with a response handshake and a PREADY watchdog that aborts stalled transfers.
module apb_master_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]       state, state_nx;
    logic             armed;
    logic [CNT_W-1:0] wd_cnt;
    logic             accept, done, abort, wd_hit;

    // Bus strobes decode straight from state so an async reset drops them without a clock edge
    assign cmd_ready = armed && state == IDLE;
    assign PSELx     = state == SETUP || state == ACCESS;
    assign PENABLE   = state == ACCESS;
    assign rsp_valid = state == RESP;
    assign accept    = cmd_valid && cmd_ready;
    assign wd_hit    = (TIMEOUT_CYCLES != 0) && wd_cnt == CNT_LAST;
    assign done      = state == ACCESS && PREADY;
    assign abort     = state == ACCESS && !PREADY && wd_hit;

    always_comb begin
        state_nx = (state == IDLE)   ? (accept ? SETUP : IDLE) :
                   (state == SETUP)  ? ACCESS :
                   (state == ACCESS) ? ((done || abort) ? RESP : ACCESS) :
                                       (rsp_ready ? IDLE : RESP);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else if (accept) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_write ? cmd_wdata : '0;
        end
    end

    // Counts consecutive low-PREADY ACCESS cycles; the abort fires on the TIMEOUT_CYCLES-th one
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            wd_cnt <= '0;
        else if (state == SETUP)
            wd_cnt <= '0;
        else if (state == ACCESS && !PREADY && wd_cnt != CNT_MAX)
            wd_cnt <= wd_cnt + 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (done) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
        end else if (abort) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed transfers against a cycle-timeline model of each transaction,
// checked every cycle, plus literal pins on key cycles.
module tb_apb_master_ctrl;
    localparam int T = 4;

    logic        PCLK = 1'b0, PRESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0, PRDATA = '0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE, PWRITE;
    logic [31:0] rsp_rdata, PADDR, PWDATA;

    apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // a: accept edge (SETUP cycle), l: ACCESS length, h: first IDLE cycle after handshake
    typedef struct {
        int          a, l, h, w;
        logic        wr, serr;
        logic [31:0] addr, wdata, rdata;
    } xfer_t;

    xfer_t       q[$];
    int          cyc = 0, last_h = 0, n_chk = 0, n_err = 0;
    logic        armed;
    logic [31:0] ex_addr = '0, ex_wdata = '0, ex_rdata = '0;
    logic        ex_write = 1'b0, ex_err = 1'b0, ex_to = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) armed <= 1'b0;
        else armed <= 1'b1;

    function automatic int cur();
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].a <= cyc) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Slave responder: waits w cycles (PSLVERR=1 noise while waiting), then answers
    always @(posedge PCLK) begin
        int    i, k;
        xfer_t r;
        #1;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0; rsp_ready = 1'b0;
        i = cur();
        if (i >= 0) begin
            r = q[i];
            k = cyc - r.a - 1;
            if (k >= 0 && k < r.l) begin
                PREADY  = k >= r.w;
                PSLVERR = (k >= r.w) ? r.serr : 1'b1;
                PRDATA  = (k >= r.w) ? r.rdata : 32'hBAD0_0000 + k;
            end
            rsp_ready = cyc == r.h - 1;
        end
    end

    always @(negedge PCLK) begin
        int    i;
        xfer_t r;
        logic  setup, acc, resp, to;
        if (!PRESETn) begin
            ex_addr = '0; ex_wdata = '0; ex_rdata = '0;
            ex_write = 1'b0; ex_err = 1'b0; ex_to = 1'b0;
            chk("rst PSELx", PSELx, 0);
            chk("rst PENABLE", PENABLE, 0);
            chk("rst rsp_valid", rsp_valid, 0);
            chk("rst cmd_ready", cmd_ready, 0);
        end else begin
            setup = 1'b0; acc = 1'b0; resp = 1'b0;
            i = cur();
            if (i >= 0) begin
                r = q[i];
                setup = cyc == r.a;
                acc   = cyc > r.a && cyc <= r.a + r.l;
                resp  = cyc > r.a + r.l && cyc < r.h;
                if (setup) begin
                    ex_write = r.wr; ex_addr = r.addr; ex_wdata = r.wr ? r.wdata : 32'h0;
                end
                if (cyc == r.a + r.l + 1) begin
                    to = r.w >= T;
                    ex_err = to || r.serr; ex_to = to;
                    ex_rdata = (r.wr || to) ? 32'h0 : r.rdata;
                end
            end
            chk("PSELx", PSELx, setup || acc);
            chk("PENABLE", PENABLE, acc);
            chk("rsp_valid", rsp_valid, resp);
            chk("cmd_ready", cmd_ready, armed && !(setup || acc || resp));
            chk("PWRITE", PWRITE, ex_write);
            chk("PADDR", PADDR, ex_addr);
            chk("PWDATA", PWDATA, ex_wdata);
            chk("rsp_rdata", rsp_rdata, ex_rdata);
            chk("rsp_err", rsp_err, ex_err);
            chk("rsp_timeout", rsp_timeout, ex_to);
        end
    end

    task automatic to_cyc(input int c);
        while (cyc < c) begin
            @(posedge PCLK);
            #2;
        end
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, wdata, rdata, input int w,
                        input logic serr, input int bp, input logic blocking, output int a);
        xfer_t r;
        r.l = (w >= T) ? T : w + 1;
        r.a = (cyc + 1 > last_h + 1) ? cyc + 1 : last_h + 1;
        r.h = r.a + r.l + 2 + bp;
        r.w = w; r.wr = wr; r.serr = serr; r.addr = addr; r.wdata = wdata; r.rdata = rdata;
        a = r.a;
        last_h = r.h;
        q.push_back(r);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        to_cyc(r.a);
        cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFF0; cmd_wdata = 32'hFFFF_FFFF;
        if (blocking) to_cyc(r.h);
    endtask

    initial begin
        int a, a2, h1;
        repeat (3) @(posedge PCLK);
        #2 PRESETn = 1'b1;
        @(posedge PCLK); #2;
        chk("pin cmd_ready after release", cmd_ready, 1);
        chk("pin PADDR after reset", PADDR, 0);

        // zero-wait write
        xfer(1'b1, 32'h8, 32'h1A5, 32'h5555, 0, 1'b0, 0, 1'b0, a);
        chk("pin wr SETUP PSELx", PSELx, 1);
        chk("pin wr SETUP PENABLE", PENABLE, 0);
        to_cyc(a + 1);
        chk("pin wr ACCESS PENABLE", PENABLE, 1);
        chk("pin wr PADDR", PADDR, 32'h8);
        chk("pin wr PWDATA", PWDATA, 32'h1A5);
        to_cyc(a + 2);
        chk("pin wr rsp_valid", rsp_valid, 1);
        chk("pin wr rsp_rdata", rsp_rdata, 0);
        chk("pin wr PSELx dropped", PSELx, 0);
        to_cyc(last_h);

        // read with 3 wait states
        xfer(1'b0, 32'h4, 32'h1234, 32'hDEADBEEF, 3, 1'b0, 0, 1'b0, a);
        to_cyc(a + 4);
        chk("pin rd3 still ACCESS", PENABLE, 1);
        chk("pin rd3 rsp_valid early", rsp_valid, 0);
        to_cyc(a + 5);
        chk("pin rd3 rsp_valid", rsp_valid, 1);
        chk("pin rd3 rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("pin rd3 PWDATA", PWDATA, 0);
        to_cyc(last_h);

        // slave error, zero wait, then PSLVERR noise during waits must be ignored
        xfer(1'b0, 32'h4, 32'h0, 32'h0000_0077, 0, 1'b1, 0, 1'b0, a);
        to_cyc(a + 2);
        chk("pin serr rsp_err", rsp_err, 1);
        chk("pin serr rsp_timeout", rsp_timeout, 0);
        to_cyc(last_h);
        xfer(1'b1, 32'h10, 32'h2222, 32'h0, 2, 1'b0, 0, 1'b0, a);
        to_cyc(a + 4);
        chk("pin waits ignore PSLVERR", rsp_err, 0);
        to_cyc(last_h);

        // watchdog timeout after T low-PREADY cycles
        xfer(1'b0, 32'h20, 32'h0, 32'hCAFE, 99, 1'b0, 0, 1'b0, a);
        to_cyc(a + 4);
        chk("pin to last ACCESS PSELx", PSELx, 1);
        to_cyc(a + 5);
        chk("pin to PSELx", PSELx, 0);
        chk("pin to rsp_timeout", rsp_timeout, 1);
        chk("pin to rsp_err", rsp_err, 1);
        chk("pin to rsp_rdata", rsp_rdata, 0);
        to_cyc(last_h);
        xfer(1'b1, 32'h24, 32'hABCD, 32'h0, 0, 1'b0, 0, 1'b1, a);
        chk("pin after to rsp_timeout", rsp_timeout, 0);

        // backpressure with a command held while busy
        xfer(1'b0, 32'h30, 32'h0, 32'h1357_2468, 1, 1'b0, 5, 1'b0, a);
        h1 = last_h;
        to_cyc(a + 3);
        xfer(1'b1, 32'h34, 32'h99, 32'h0, 0, 1'b0, 0, 1'b0, a2);
        chk("pin bp accept cycle", a2 - a, 10);
        chk("pin bp new PADDR", PADDR, 32'h34);
        chk("pin bp old rdata kept", rsp_rdata, 32'h1357_2468);
        to_cyc(last_h);
        if (h1 >= last_h) chk("bp ordering", 0, 1);

        for (int i = 0; i < 4; i++)
            xfer(i[0], 32'h100 + i * 4, 32'hA000 + i, 32'h5A5A_0000 + i, i, i == 2, i, 1'b1, a);

        // reset during ACCESS wait state
        xfer(1'b0, 32'h40, 32'h0, 32'h1111, 2, 1'b0, 0, 1'b0, a);
        to_cyc(a + 2);
        #1 PRESETn = 1'b0;
        q.delete();
        last_h = 0;
        #1;
        chk("pin async rst PSELx", PSELx, 0);
        chk("pin async rst PENABLE", PENABLE, 0);
        repeat (2) @(posedge PCLK);
        #2 PRESETn = 1'b1;
        @(posedge PCLK); #2;
        chk("pin post-rst cmd_ready", cmd_ready, 1);
        chk("pin post-rst rsp_valid", rsp_valid, 0);
        xfer(1'b1, 32'h44, 32'h4444, 32'h0, 0, 1'b0, 0, 1'b1, a);
        chk("pin post-rst PWDATA", PWDATA, 32'h4444);

        repeat (3) @(posedge PCLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
